// File: rtl/stone_ram_pkg.sv
// Shared types and constants for the stone RAM and its arbiter.
// Holds RAM geometry, arbiter states and the stone word layout.
package stone_ram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    // Stone word field offsets
    localparam int X_HI    = 31;
    localparam int X_LO    = 23;
    localparam int Y_HI    = 18;
    localparam int Y_LO    = 11;
    localparam int TYPE_HI = 3;
    localparam int TYPE_LO = 2;
    localparam int VIS_BIT = 1;
    localparam int MOV_BIT = 0;

    typedef struct packed {
        logic [8:0] x;
        logic [3:0] rsvd_hi;
        logic [7:0] y;
        logic [6:0] rsvd_lo;
        logic [1:0] kind;
        logic       visible;
        logic       moving;
    } stone_t;

    function automatic stone_t to_stone(logic [DATA_W-1:0] word);
        return stone_t'(word);
    endfunction

    function automatic logic stone_visible(logic [DATA_W-1:0] word);
        return word[VIS_BIT];
    endfunction

endpackage

// File: rtl/stone_ram_arbiter_if.sv
// Renderer, rope controller and RAM signals seen by the arbiter.
// slave is the arbiter view, master is the requester/RAM side.
interface stone_ram_arbiter_if;
    import stone_ram_pkg::*;

    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic              draw_gnt;
    logic              draw_rvalid;
    logic [DATA_W-1:0] draw_rdata;

    logic              rope_req;
    logic              rope_we;
    logic [ADDR_W-1:0] rope_addr;
    logic [DATA_W-1:0] rope_wdata;
    logic              rope_lock;
    logic              rope_gnt;
    logic              rope_rvalid;
    logic [DATA_W-1:0] rope_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    logic              lock_err;

    modport slave (
        input  draw_req, draw_addr,
        input  rope_req, rope_we, rope_addr, rope_wdata, rope_lock,
        input  ram_q,
        output draw_gnt, draw_rvalid, draw_rdata,
        output rope_gnt, rope_rvalid, rope_rdata,
        output ram_address, ram_data, ram_wren,
        output lock_err
    );

    modport master (
        output draw_req, draw_addr,
        output rope_req, rope_we, rope_addr, rope_wdata, rope_lock,
        output ram_q,
        input  draw_gnt, draw_rvalid, draw_rdata,
        input  rope_gnt, rope_rvalid, rope_rdata,
        input  ram_address, ram_data, ram_wren,
        input  lock_err
    );

endinterface

// File: rtl/stone_ram_arbiter.sv
// Arbitrates the single-port stone RAM between renderer and rope.
// Bounded rope latency via a draw streak limit; atomic locked rope updates.
module stone_ram_arbiter
    import stone_ram_pkg::*;
#(
    parameter int MAX_DRAW_STREAK = 8,
    parameter int LOCK_TIMEOUT    = 16
) (
    input logic                clock,
    input logic                resetn,
    stone_ram_arbiter_if.slave bus
);

    localparam int SW = $clog2(MAX_DRAW_STREAK + 1);
    localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DRAW_STREAK);
    localparam logic [LW-1:0] CNT_LAST   = LW'(LOCK_TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nx;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_nx;
    logic          lock_err_q;
    logic          lock_err_nx;
    logic          draw_gnt;
    logic          rope_gnt;
    logic          draw_rvalid_q;
    logic          rope_rvalid_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            streak        <= '0;
            lock_cnt      <= '0;
            lock_err_q    <= 1'b0;
            draw_rvalid_q <= 1'b0;
            rope_rvalid_q <= 1'b0;
        end else begin
            state         <= state_nx;
            streak        <= streak_nx;
            lock_cnt      <= lock_cnt_nx;
            lock_err_q    <= lock_err_nx;
            draw_rvalid_q <= draw_gnt;
            rope_rvalid_q <= rope_gnt && !bus.rope_we;
        end
    end

    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        lock_err_nx = lock_err_q;
        draw_gnt    = 1'b0;
        rope_gnt    = 1'b0;
        unique case (state)
            S_IDLE: begin
                rope_gnt = bus.rope_req &&
                           (!bus.draw_req || streak >= STREAK_MAX);
                draw_gnt = bus.draw_req && !rope_gnt;
                if (rope_gnt && bus.rope_lock) begin
                    state_nx    = S_LOCK;
                    lock_cnt_nx = '0;
                end
            end
            S_LOCK: begin
                rope_gnt    = bus.rope_req;
                lock_cnt_nx = lock_cnt + 1'b1;
                // A release wins over a simultaneous timeout
                if (!bus.rope_lock) begin
                    state_nx = S_IDLE;
                end else if (lock_cnt == CNT_LAST) begin
                    state_nx    = S_IDLE;
                    lock_err_nx = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        streak_nx = streak;
        if (rope_gnt || !bus.rope_req) begin
            streak_nx = '0;
        end else if (draw_gnt && streak < STREAK_MAX) begin
            streak_nx = streak + 1'b1;
        end
    end

    always_comb begin
        bus.ram_address = '0;
        if (rope_gnt) begin
            bus.ram_address = bus.rope_addr;
        end else if (draw_gnt) begin
            bus.ram_address = bus.draw_addr;
        end
    end

    assign bus.ram_wren    = rope_gnt && bus.rope_we;
    assign bus.ram_data    = bus.rope_wdata;
    assign bus.draw_gnt    = draw_gnt;
    assign bus.rope_gnt    = rope_gnt;
    assign bus.draw_rvalid = draw_rvalid_q;
    assign bus.rope_rvalid = rope_rvalid_q;
    assign bus.draw_rdata  = bus.ram_q;
    assign bus.rope_rdata  = bus.ram_q;
    assign bus.lock_err    = lock_err_q;

endmodule

// File: tb/tb_stone_ram_arbiter.sv
// Scoreboard bench for stone_ram_arbiter with a behavioural RAM and
// a cycle-level reference of the arbitration rules.
module tb_stone_ram_arbiter;
    import stone_ram_pkg::*;

    localparam int MAXS = 8;
    localparam int TMO  = 16;

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } rd_t;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    stone_ram_arbiter_if bus();

    stone_ram_arbiter #(
        .MAX_DRAW_STREAK(MAXS),
        .LOCK_TIMEOUT   (TMO)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    // Behavioural RAM with registered address
    logic [31:0] mem [16];
    logic [3:0]  ram_aq;
    logic        pl_we = 1'b0;
    logic [3:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    always @(posedge clock) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        ram_aq <= bus.ram_address;
    end
    assign bus.ram_q = mem[ram_aq];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    rd_t dq[$];
    rd_t rq[$];
    logic [31:0] shadow [16];
    bit g_draw = 0, g_rope = 0;
    int n_dgnt = 0, n_rgnt = 0;
    bit m_locked = 0, m_err = 0;
    int m_streak = 0, m_age = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: grants, RAM strobes, expected read data
    always @(negedge clock) begin : model
        bit ed, er;
        logic [3:0] ea;
        if (!resetn) begin
            chk("rst_draw_rvalid", 32'(bus.draw_rvalid), 32'd0);
            chk("rst_rope_rvalid", 32'(bus.rope_rvalid), 32'd0);
            chk("rst_lock_err", 32'(bus.lock_err), 32'd0);
            dq.delete();
            rq.delete();
            m_locked = 0; m_err = 0; m_streak = 0; m_age = 0;
            g_draw = 0; g_rope = 0;
            if (pl_we) shadow[pl_a] = pl_d;
        end else begin
            if (m_locked) begin
                er = bus.rope_req;
                ed = 0;
            end else begin
                er = bus.rope_req && (!bus.draw_req || m_streak >= MAXS);
                ed = bus.draw_req && !er;
            end
            ea = er ? bus.rope_addr : (ed ? bus.draw_addr : 4'd0);
            chk("draw_gnt", 32'(bus.draw_gnt), 32'(ed));
            chk("rope_gnt", 32'(bus.rope_gnt), 32'(er));
            chk("ram_address", 32'(bus.ram_address), 32'(ea));
            chk("ram_wren", 32'(bus.ram_wren), 32'(er && bus.rope_we));
            if (er && bus.rope_we)
                chk("ram_data", bus.ram_data, bus.rope_wdata);
            chk("lock_err", 32'(bus.lock_err), 32'(m_err));
            if (bus.draw_gnt) n_dgnt++;
            if (bus.rope_gnt) n_rgnt++;
            if (ed) dq.push_back('{shadow[bus.draw_addr], cyc});
            if (er) begin
                if (bus.rope_we) shadow[bus.rope_addr] = bus.rope_wdata;
                else rq.push_back('{shadow[bus.rope_addr], cyc});
            end
            if (m_locked) begin
                m_age++;
                if (!bus.rope_lock) begin
                    m_locked = 0;
                end else if (m_age == TMO) begin
                    m_locked = 0;
                    m_err = 1;
                end
            end else if (er && bus.rope_lock) begin
                m_locked = 1;
                m_age = 0;
            end
            if (er || !bus.rope_req) m_streak = 0;
            else if (ed && m_streak < MAXS) m_streak++;
            g_draw = ed;
            g_rope = er;
        end
    end

    // Monitor: pops expected responses when the DUT presents rvalid
    always @(negedge clock) begin : monitor
        rd_t de, re;
        if (resetn) begin
            if (bus.draw_rvalid) begin
                if (dq.size() == 0) begin
                    chk("draw_rvalid_spurious", 32'd1, 32'd0);
                end else begin
                    de = dq.pop_front();
                    chk("draw_rdata", bus.draw_rdata, de.d);
                    chk("draw_latency", 32'(cyc - de.cyc), 32'd1);
                end
            end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
                chk("draw_rvalid_missing", 32'd0, 32'd1);
                de = dq.pop_front();
            end
            if (bus.rope_rvalid) begin
                if (rq.size() == 0) begin
                    chk("rope_rvalid_spurious", 32'd1, 32'd0);
                end else begin
                    re = rq.pop_front();
                    chk("rope_rdata", bus.rope_rdata, re.d);
                    chk("rope_latency", 32'(cyc - re.cyc), 32'd1);
                end
            end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rope_rvalid_missing", 32'd0, 32'd1);
                re = rq.pop_front();
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_draw(logic [3:0] a);
        bit ok = 0;
        bus.draw_req = 1'b1;
        bus.draw_addr = a;
        for (int n = 0; n < 40 && !ok; n++) begin
            next_cycle();
            ok = g_draw;
        end
        if (!ok) chk("draw_wait_timeout", 32'd0, 32'd1);
        bus.draw_req = 1'b0;
    endtask

    task automatic do_rope(logic we, logic [3:0] a, logic [31:0] d,
                           logic lk);
        bit ok = 0;
        bus.rope_req = 1'b1;
        bus.rope_we = we;
        bus.rope_addr = a;
        bus.rope_wdata = d;
        bus.rope_lock = lk;
        for (int n = 0; n < 40 && !ok; n++) begin
            next_cycle();
            ok = g_rope;
        end
        if (!ok) chk("rope_wait_timeout", 32'd0, 32'd1);
        bus.rope_req = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int d0, r0;
        bus.draw_req = 0; bus.draw_addr = '0;
        bus.rope_req = 0; bus.rope_we = 0; bus.rope_addr = '0;
        bus.rope_wdata = '0; bus.rope_lock = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            pl_we = 1'b1;
            pl_a = 4'(i);
            pl_d = (i == 3) ? 32'h0123_4567 : $urandom;
        end
        next_cycle();
        pl_we = 1'b0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // Draw only
        do_draw(4'd3);
        repeat (2) next_cycle();

        // Rope write then read back
        do_rope(1'b1, 4'd5, 32'hA5A5_0009, 1'b0);
        do_rope(1'b0, 4'd5, 32'h0, 1'b0);
        repeat (2) next_cycle();

        // Starvation: 8 draws then 1 rope, repeating
        d0 = n_dgnt; r0 = n_rgnt;
        bus.draw_req = 1; bus.draw_addr = 4'd1;
        bus.rope_req = 1; bus.rope_we = 0; bus.rope_addr = 4'd7;
        bus.rope_lock = 0;
        repeat (18) next_cycle();
        chk("starve_draws", 32'(n_dgnt - d0), 32'd16);
        chk("starve_ropes", 32'(n_rgnt - r0), 32'd2);
        bus.draw_req = 0; bus.rope_req = 0;
        repeat (2) next_cycle();

        // Locked read-modify-write with draw pending throughout
        bus.draw_req = 1; bus.draw_addr = 4'd4;
        do_rope(1'b0, 4'd2, 32'h0, 1'b1);
        d0 = n_dgnt;
        next_cycle();
        bus.rope_req = 1; bus.rope_we = 1; bus.rope_addr = 4'd2;
        bus.rope_wdata = 32'h5A5A_1234; bus.rope_lock = 0;
        next_cycle();
        chk("rmw_no_draw_in_lock", 32'(n_dgnt - d0), 32'd0);
        bus.rope_req = 0;
        next_cycle();
        chk("rmw_draw_after_release", 32'(n_dgnt - d0), 32'd1);
        chk("rmw_lock_err", 32'(bus.lock_err), 32'd0);
        bus.draw_req = 0;
        do_draw(4'd2);
        repeat (2) next_cycle();

        // Lock timeout
        bus.rope_req = 1; bus.rope_we = 0; bus.rope_addr = 4'd9;
        bus.rope_lock = 1;
        next_cycle();
        bus.draw_req = 1; bus.draw_addr = 4'd6;
        d0 = n_dgnt;
        repeat (16) next_cycle();
        chk("tmo_no_draw", 32'(n_dgnt - d0), 32'd0);
        next_cycle();
        chk("tmo_draw_next", 32'(n_dgnt - d0), 32'd1);
        chk("tmo_lock_err", 32'(bus.lock_err), 32'd1);
        bus.rope_req = 0; bus.rope_lock = 0; bus.draw_req = 0;
        repeat (3) next_cycle();
        chk("lock_err_sticky", 32'(bus.lock_err), 32'd1);

        // Async reset while a draw read is in flight
        do_draw(4'd3);
        resetn = 1'b0;
        #1;
        chk("async_rst_draw_rvalid", 32'(bus.draw_rvalid), 32'd0);
        chk("async_rst_lock_err", 32'(bus.lock_err), 32'd0);
        chk("async_rst_ram_wren", 32'(bus.ram_wren), 32'd0);
        repeat (2) next_cycle();
        resetn = 1'b1;
        next_cycle();
        do_draw(4'd3);
        repeat (2) next_cycle();

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            if (!bus.draw_req || g_draw) begin
                bus.draw_req = ($urandom % 10) < 6;
                bus.draw_addr = 4'($urandom);
            end
            if (!bus.rope_req || g_rope) begin
                bus.rope_req = ($urandom % 10) < 4;
                bus.rope_we = 1'($urandom);
                bus.rope_addr = 4'($urandom);
                bus.rope_wdata = $urandom;
                bus.rope_lock = ($urandom % 10) < 3;
            end
            next_cycle();
        end
        bus.draw_req = 0; bus.rope_req = 0; bus.rope_lock = 0;
        repeat (4) next_cycle();
        chk("draw_queue_drained", 32'(dq.size()), 32'd0);
        chk("rope_queue_drained", 32'(rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
